// File: rtl/pluck_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pluck_pkg
// Description : Shared types and default constants for the plucked-string
//               voice sequencer.
//               - pluck_state_t : sequencer FSM state encoding
//               - LEN_W_DEF     : default delay-length width
//               - SUS_W_DEF     : default sustain-counter width
//               - MIN_LEN       : smallest legal delay length
//               - CLR_CYC_DEF   : default number of delay-line clear cycles
// Revision    : 1.0 - initial release
// ============================================================================
package pluck_pkg;

    localparam int LEN_W_DEF   = 10;
    localparam int SUS_W_DEF   = 24;
    localparam int MIN_LEN     = 2;
    localparam int CLR_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2,
        RING  = 2'd3
    } pluck_state_t;

endpackage : pluck_pkg
`default_nettype wire

// File: rtl/pluck_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pluck_down_counter
// Description : Unsigned down-counter that saturates at zero. A phase of N
//               cycles is timed by loading N-1; the zero flag marks the last
//               cycle of the phase.
// Ports       : clk      - system clock
//               reset_n  - synchronous reset, active-high
//               load     - load load_val (takes priority over en)
//               load_val - value to load
//               en       - decrement enable (holds at zero, never wraps)
//               zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module pluck_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : pluck_down_counter
`default_nettype wire

// File: rtl/pluck_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pluck_sequencer
// Description : Sequences one plucked-string voice on the feedback delay line:
//               accept note -> clear delay line (CLR_CYC cycles) -> fill with
//               noise for one delay period (len cycles) -> ring for the
//               sustain time or until note_off.
// Ports       : clk        - system clock
//               reset_n    - synchronous reset, active-high (despite name)
//               note_valid - note request present
//               note_ready - request accepted this cycle (combinational)
//               note_len   - delay length, sampled on accept, clamped to
//                            MIN_LEN
//               note_sus   - ring cycles after fill, 0 = until note_off
//               note_off   - single-cycle release request
//               sr_clear   - delay-line clear
//               trig       - 1 = noise into delay line, 0 = feedback
//               sr_length  - delay length to the delay line
//               busy       - sequencer not idle
//               done       - one-cycle pulse on return to IDLE
// Config      : PLUCK_RETRIGGER_EN - when defined, a new note may be accepted
//               while ringing and restarts the voice without a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pluck_sequencer
    import pluck_pkg::*;
#(
    parameter int LEN_W   = pluck_pkg::LEN_W_DEF,
    parameter int SUS_W   = pluck_pkg::SUS_W_DEF,
    parameter int MIN_LEN = pluck_pkg::MIN_LEN,
    parameter int CLR_CYC = pluck_pkg::CLR_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [LEN_W-1:0] note_len,
    input  logic [SUS_W-1:0] note_sus,
    input  logic             note_off,
    output logic             sr_clear,
    output logic             trig,
    output logic [LEN_W-1:0] sr_length,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] c_MIN_LEN  = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] c_CLR_LOAD = LEN_W'(CLR_CYC - 1);

    pluck_state_t     r_state;
    pluck_state_t     w_next_state;

    logic [LEN_W-1:0] r_len;
    logic [SUS_W-1:0] r_sus;
    logic             r_pend;       // note_off seen during FILL
    logic             r_clear;
    logic             r_trig;
    logic             r_busy;
    logic             r_done;

    logic             w_ready;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_clamped;

    logic             w_ld_phase;
    logic [LEN_W-1:0] w_ld_phase_val;
    logic             w_zero_phase;
    logic             w_ld_sus;
    logic [SUS_W-1:0] w_ld_sus_val;
    logic             w_zero_sus;

    logic             w_clear;
    logic             w_trig;
    logic             w_busy;
    logic             w_done;

`ifdef PLUCK_RETRIGGER_EN
    assign w_ready = (r_state == IDLE) || (r_state == RING);
`else
    assign w_ready = (r_state == IDLE);
`endif

    assign note_ready    = w_ready;
    assign w_accept      = note_valid && w_ready;
    assign w_len_clamped = (note_len < c_MIN_LEN) ? c_MIN_LEN : note_len;

    // One counter times both CLEAR and FILL since they never overlap.
    pluck_down_counter #(
        .WIDTH (LEN_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_ld_phase),
        .load_val (w_ld_phase_val),
        .en       ((r_state == CLEAR) || (r_state == FILL)),
        .zero     (w_zero_phase)
    );

    pluck_down_counter #(
        .WIDTH (SUS_W)
    ) u_sus_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_ld_sus),
        .load_val (w_ld_sus_val),
        .en       (r_state == RING),
        .zero     (w_zero_sus)
    );

    // ------------------------------------------------------------------
    // State register, latched note parameters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= IDLE;
            r_len   <= c_MIN_LEN;
            r_sus   <= '0;
            r_pend  <= 1'b0;
            r_clear <= 1'b0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_clear <= w_clear;
            r_trig  <= w_trig;
            r_busy  <= w_busy;
            r_done  <= w_done;
            if (w_accept) begin
                r_len <= w_len_clamped;
                r_sus <= note_sus;
            end
            // Flag lives only while FILL continues; it is consumed at FILL end.
            r_pend <= (r_state == FILL) && (w_next_state == FILL) && (r_pend || note_off);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter-load logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_ld_phase     = 1'b0;
        w_ld_phase_val = '0;
        w_ld_sus       = 1'b0;
        w_ld_sus_val   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state   = CLEAR;
                    w_ld_phase     = 1'b1;
                    w_ld_phase_val = c_CLR_LOAD;
                end
            end
            CLEAR: begin
                if (w_zero_phase) begin
                    w_next_state   = FILL;
                    w_ld_phase     = 1'b1;
                    w_ld_phase_val = r_len - LEN_W'(1);
                end
            end
            FILL: begin
                // A release on the last FILL cycle counts as well.
                if (w_zero_phase) begin
                    if (r_pend || note_off) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = RING;
                        w_ld_sus     = 1'b1;
                        w_ld_sus_val = (r_sus == '0) ? '0 : (r_sus - SUS_W'(1));
                    end
                end
            end
            RING: begin
                // w_accept can only be set here in the retrigger build;
                // it wins over a simultaneous note_off.
                if (w_accept) begin
                    w_next_state   = CLEAR;
                    w_ld_phase     = 1'b1;
                    w_ld_phase_val = c_CLR_LOAD;
                end else if (note_off) begin
                    w_next_state = IDLE;
                end else if ((r_sus != '0) && w_zero_sus) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the upcoming state, registered above
    // ------------------------------------------------------------------
    always_comb begin
        w_clear = (w_next_state == CLEAR);
        w_trig  = (w_next_state == FILL);
        w_busy  = (w_next_state != IDLE);
        w_done  = (w_next_state == IDLE) && ((r_state == FILL) || (r_state == RING));
    end

    assign sr_clear  = r_clear;
    assign trig      = r_trig;
    assign sr_length = r_len;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : pluck_sequencer
`default_nettype wire

// File: tb/tb_pluck_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pluck_sequencer
// Description : Self-checking bench for pluck_sequencer. Expected outputs come
//               from a phase-arithmetic model of one note: CLR_CYC clear
//               cycles, len fill cycles, then a ring phase whose end is set by
//               the sustain count or the note_off time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pluck_sequencer;

    localparam int LEN_W   = 10;
    localparam int SUS_W   = 24;
    localparam int MIN_LEN = 2;
    localparam int CLR     = 2;
`ifdef PLUCK_RETRIGGER_EN
    localparam bit RETRIG  = 1'b1;
`else
    localparam bit RETRIG  = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b1;
    logic             note_valid = 1'b0;
    logic             note_off   = 1'b0;
    logic [LEN_W-1:0] note_len   = '0;
    logic [SUS_W-1:0] note_sus   = '0;
    logic             note_ready;
    logic             sr_clear;
    logic             trig;
    logic [LEN_W-1:0] sr_length;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pluck_sequencer #(
        .LEN_W   (LEN_W),
        .SUS_W   (SUS_W),
        .MIN_LEN (MIN_LEN),
        .CLR_CYC (CLR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_len   (note_len),
        .note_sus   (note_sus),
        .note_off   (note_off),
        .sr_clear   (sr_clear),
        .trig       (trig),
        .sr_length  (sr_length),
        .busy       (busy),
        .done       (done)
    );

    function automatic int clamp_len(input int l);
        return (l < MIN_LEN) ? MIN_LEN : l;
    endfunction

    // Number of busy cycles after accept. off_k is the cycle index (0 = first
    // cycle after the accept edge) in which note_off is held; -1 = never.
    function automatic int note_end(input int l, input int s, input int off_k);
        int f;
        f = CLR + l;
        if (off_k >= CLR && off_k < f) return f;
        if (s > 0) return (off_k >= f && off_k < f + s) ? off_k + 1 : f + s;
        return off_k + 1;
    endfunction

    // Called on the negedge right after an accept edge. Checks cycles
    // 0 .. stop-1 (stop < 0: through two idle cycles after the note).
    task automatic expect_note(input int len_req, input int s, input int off_k, input int stop);
        int l, e, last;
        logic [4:0] exp_v, got_v;
        logic rdy;
        l    = clamp_len(len_req);
        e    = note_end(l, s, off_k);
        last = (stop < 0) ? e + 2 : stop;
        for (int k = 0; k < last; k++) begin
            rdy   = (k >= e) || (RETRIG && (k >= CLR + l) && (k < e));
            exp_v = {(k < CLR), (k >= CLR) && (k < CLR + l), (k < e), (k == e), rdy};
            got_v = {sr_clear, trig, busy, done, note_ready};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL note_outputs len=%0d sus=%0d k=%0d {clr,trig,busy,done,rdy} got %b expected %b",
                         l, s, k, got_v, exp_v);
            end
            n_checks++;
            if (sr_length !== LEN_W'(l)) begin
                n_errors++;
                $display("FAIL sr_length k=%0d got %0d expected %0d", k, sr_length, l);
            end
            note_off = (k == off_k);
            if (!RETRIG && k < e) begin
                // Back-pressured requests must not disturb the running note.
                note_valid = 1'($urandom_range(0, 1));
                note_len   = LEN_W'($urandom);
            end else begin
                note_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        note_off   = 1'b0;
        note_valid = 1'b0;
    endtask

    task automatic accept_note(input int len_req, input int s);
        note_valid = 1'b1;
        note_len   = LEN_W'(len_req);
        note_sus   = SUS_W'(s);
        n_checks++;
        if (note_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready got %b expected 1", note_ready);
        end
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        note_sus   = SUS_W'($urandom);
    endtask

    task automatic run_note(input int len_req, input int s, input int off_k);
        accept_note(len_req, s);
        expect_note(len_req, s, off_k, -1);
    endtask

    task automatic idle_gap(input int n);
        logic [4:0] got_v;
        for (int i = 0; i < n; i++) begin
            got_v = {sr_clear, trig, busy, done, note_ready};
            n_checks++;
            if (got_v !== 5'b00001) begin
                n_errors++;
                $display("FAIL idle_outputs i=%0d got %b expected 00001", i, got_v);
            end
            note_off = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        note_off = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got_v;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        got_v = {sr_clear, trig, busy, done, note_ready};
        n_checks++;
        if (got_v !== 5'b00001) begin
            n_errors++;
            $display("FAIL reset_outputs got %b expected 00001", got_v);
        end
        n_checks++;
        if (sr_length !== LEN_W'(MIN_LEN)) begin
            n_errors++;
            $display("FAIL reset_sr_length got %0d expected %0d", sr_length, MIN_LEN);
        end
    endtask

    task automatic test_basic();
        run_note(100, 500, -1);
        idle_gap(3);
    endtask

    task automatic test_clamp();
        run_note(0, 10, -1);
        run_note(1, 5, -1);
        run_note(2, 3, -1);
        idle_gap(2);
    endtask

    task automatic test_sustain_zero();
        run_note(7, 0, CLR + 7 + 10000);
        idle_gap(2);
    endtask

    task automatic test_release_in_fill();
        run_note(50, 300, CLR + 4);
        run_note(20, 40, 1);
        run_note(20, 40, CLR + 19);
        idle_gap(2);
    endtask

    task automatic test_random();
        int l, s, f, off_k;
        for (int n = 0; n < 20; n++) begin
            l     = int'($urandom_range(0, 40));
            s     = int'($urandom_range(0, 60));
            f     = CLR + clamp_len(l);
            off_k = int'($urandom_range(0, f + s + 3));
            if (s == 0 && off_k < f) off_k = f + off_k;
            if (s > 0 && $urandom_range(0, 2) == 0) off_k = -1;
            run_note(l, s, off_k);
            idle_gap(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        run_note(5, 4, -1);
        run_note(9, 0, CLR + 9 + 3);
        idle_gap(1);
    endtask

`ifdef PLUCK_RETRIGGER_EN
    task automatic test_retrigger();
        accept_note(100, 500);
        expect_note(100, 500, -1, CLR + 110);
        note_off = 1'b1;
        accept_note(200, 30);
        note_off = 1'b0;
        expect_note(200, 30, -1, -1);
    endtask
`endif

    task automatic test_reset_mid_fill();
        logic [4:0] got_v;
        accept_note(30, 10);
        expect_note(30, 10, -1, CLR + 5);
        reset_n    = 1'b1;
        note_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        got_v = {sr_clear, trig, busy, done, note_ready};
        n_checks++;
        if (got_v !== 5'b00001) begin
            n_errors++;
            $display("FAIL reset_mid_fill got %b expected 00001", got_v);
        end
        n_checks++;
        if (sr_length !== LEN_W'(MIN_LEN)) begin
            n_errors++;
            $display("FAIL reset_mid_fill_len got %0d expected %0d", sr_length, MIN_LEN);
        end
        @(posedge clk);
        @(negedge clk);
        idle_gap(3);
        run_note(4, 2, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_sustain_zero();
        test_release_in_fill();
        test_back_to_back();
`ifdef PLUCK_RETRIGGER_EN
        test_retrigger();
`endif
        test_random();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pluck_sequencer
`default_nettype wire
